// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch and load/store requesters take turns on a
// single memory port. Each access holds mem_en for WAIT_CYCLES enabled cycles,
// then returns read data with a one-cycle done pulse to the granted side.
//
// Handshake: a requester raises req with its address/data and keeps req high
// until it sees its done pulse; done is high for exactly one enabled cycle and
// rdata is valid with it. A req still high when the arbiter is back in IDLE is
// a new request. Request fields are latched at grant; later changes are ignored.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              last_ls, last_ls_nx;   // 1: last grant went to load/store
  logic              grant_ls, grant_ls_nx; // 1: current access owned by load/store
  logic              pick_ls;
  logic              mem_en_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;
  logic              if_done_nx, ls_done_nx;
  logic [DATA_W-1:0] if_rdata_nx, ls_rdata_nx;
  logic              busy_nx;

  assign fsm_state = state;

  // State register; frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nx;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    last_ls_nx   = last_ls;
    grant_ls_nx  = grant_ls;
    pick_ls      = 1'b0;
    mem_en_nx    = mem_en;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_done_nx   = 1'b0;
    ls_done_nx   = 1'b0;
    if_rdata_nx  = if_rdata;
    ls_rdata_nx  = ls_rdata;
    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          // Round-robin: on contention the side that did not win last time goes.
          pick_ls      = ls_req && (!if_req || !last_ls);
          grant_ls_nx  = pick_ls;
          last_ls_nx   = pick_ls;
          mem_en_nx    = 1'b1;
          mem_we_nx    = pick_ls && ls_we;
          mem_addr_nx  = pick_ls ? ls_addr : if_addr;
          // Fetches never write, so the write data register is left alone.
          mem_wdata_nx = pick_ls ? ls_wdata : mem_wdata;
          cnt_nx       = CNT_INIT;
          state_nx     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          if (grant_ls) begin
            if (!mem_we) ls_rdata_nx = mem_rdata;
            ls_done_nx = 1'b1;
          end else begin
            if_rdata_nx = mem_rdata;
            if_done_nx  = 1'b1;
          end
          mem_en_nx = 1'b0;
          mem_we_nx = 1'b0;
          state_nx  = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Datapath and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      last_ls   <= 1'b1;
      grant_ls  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      ls_done   <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      busy      <= 1'b0;
    end else if (clk_en) begin
      cnt       <= cnt_nx;
      last_ls   <= last_ls_nx;
      grant_ls  <= grant_ls_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_done   <= if_done_nx;
      ls_done   <= ls_done_nx;
      if_rdata  <= if_rdata_nx;
      ls_rdata  <= ls_rdata_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven single-requester sequences plus
// hand-written stall, reset, contention, request-drop and WAIT_CYCLES=1 cases.
module tb_mem_port_arbiter;

  localparam logic [31:0] A10 = 32'h0000_0010;
  localparam logic [31:0] A40 = 32'h0000_0040;
  localparam logic [31:0] A80 = 32'h0000_0080;
  localparam logic [31:0] W10 = 32'h2008_0005;
  localparam logic [31:0] DBF = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, ls_done, mem_en, mem_we, busy;
  logic [1:0]  fsm_state;

  logic [31:0] u1_if_rdata, u1_ls_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
  logic        u1_if_done, u1_ls_done, u1_mem_en, u1_mem_we, u1_busy;
  logic [1:0]  u1_fsm_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(u1_if_rdata), .if_done(u1_if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(u1_ls_rdata), .ls_done(u1_ls_done),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
    .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata), .busy(u1_busy),
    .fsm_state(u1_fsm_state)
  );

  // ---------------- memory model (64 words, written only by dut) ----------------
  logic        mem_clear = 1'b1;
  logic [31:0] mem_arr [0:63];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
      mem_arr[4] <= W10;
    end else if (clk_en && mem_en && mem_we) begin
      mem_arr[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata    = mem_arr[mem_addr[7:2]];
  assign u1_mem_rdata = mem_arr[u1_mem_addr[7:2]];

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic        chk_wdata;
    logic [31:0] e_mem_wdata;
    logic        e_if_done;
    logic [31:0] e_if_rdata;
    logic        e_ls_done;
    logic [31:0] e_ls_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs [13];

  initial begin : main
    int n;
    bit seen;
    logic [7:0] ev;

    // Fetch 0x10, store 0xDEADBEEF to 0x40, fetch 0x40.
    vecs[0]  = '{1'b1, A10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b1, A10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, A10, 1'b0, 32'h0, 1'b1, W10,   1'b0, 32'h0, 1'b1};
    vecs[3]  = '{1'b0, A10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, A10, 1'b0, 32'h0, 1'b0, W10,   1'b0, 32'h0, 1'b0};
    vecs[4]  = vecs[3];
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, A40, DBF, 1'b1, 1'b1, A40, 1'b1, DBF,   1'b0, W10,   1'b0, 32'h0, 1'b1};
    vecs[6]  = vecs[5];
    vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, A40, DBF, 1'b0, 1'b0, A40, 1'b1, DBF,   1'b0, W10,   1'b1, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, A40, DBF, 1'b0, 1'b0, A40, 1'b0, 32'h0, 1'b0, W10,   1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, A40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, A40, 1'b0, 32'h0, 1'b0, W10,   1'b0, 32'h0, 1'b1};
    vecs[10] = vecs[9];
    vecs[11] = '{1'b1, A40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, A40, 1'b0, 32'h0, 1'b1, DBF,   1'b0, 32'h0, 1'b1};
    vecs[12] = '{1'b0, A40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, A40, 1'b0, 32'h0, 1'b0, DBF,   1'b0, 32'h0, 1'b0};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    chk("rst mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_done", {31'b0, if_done}, 32'h0);
    chk("rst ls_done", {31'b0, ls_done}, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst ls_rdata", ls_rdata, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst state", {30'b0, fsm_state}, 32'h0);
    rst = 1'b1;

    // ---- table-driven sequences ----
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if_req   = vecs[i].if_req;
      if_addr  = vecs[i].if_addr;
      ls_req   = vecs[i].ls_req;
      ls_we    = vecs[i].ls_we;
      ls_addr  = vecs[i].ls_addr;
      ls_wdata = vecs[i].ls_wdata;
      edge_sample();
      chk($sformatf("v%0d mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].e_mem_en});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mem_we});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      if (vecs[i].chk_wdata) chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      chk($sformatf("v%0d if_done", i), {31'b0, if_done}, {31'b0, vecs[i].e_if_done});
      chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("v%0d ls_done", i), {31'b0, ls_done}, {31'b0, vecs[i].e_ls_done});
      chk($sformatf("v%0d ls_rdata", i), ls_rdata, vecs[i].e_ls_rdata);
      chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vecs[i].e_busy});
    end

    // ---- WAIT_CYCLES=1: ACCESS lasts one enabled cycle ----
    @(negedge clk);
    if_req = 1'b1; if_addr = A10;
    edge_sample();
    chk("w1 grant mem_en", {31'b0, u1_mem_en}, 32'h1);
    chk("w1 grant mem_addr", u1_mem_addr, A10);
    edge_sample();
    chk("w1 if_done", {31'b0, u1_if_done}, 32'h1);
    chk("w1 if_rdata", u1_if_rdata, W10);
    chk("w1 mem_en cleared", {31'b0, u1_mem_en}, 32'h0);
    chk("w2 still accessing", {31'b0, mem_en}, 32'h1);
    @(negedge clk);
    if_req = 1'b0;
    edge_sample();
    chk("w2 if_done", {31'b0, if_done}, 32'h1);
    chk("w1 done cleared", {31'b0, u1_if_done}, 32'h0);
    edge_sample();

    // ---- clk_en stall for 5 cycles mid-ACCESS ----
    @(negedge clk);
    if_req = 1'b1; if_addr = A40;
    edge_sample();
    chk("stall grant mem_en", {31'b0, mem_en}, 32'h1);
    @(negedge clk);
    clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge_sample();
      chk($sformatf("stall%0d mem_en", k), {31'b0, mem_en}, 32'h1);
      chk($sformatf("stall%0d mem_addr", k), mem_addr, A40);
      chk($sformatf("stall%0d if_done", k), {31'b0, if_done}, 32'h0);
    end
    @(negedge clk);
    clk_en = 1'b1;
    n = 5;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      edge_sample();
      n++;
      if (if_done) seen = 1'b1;
    end
    chk("stall done seen", {31'b0, seen}, 32'h1);
    chk("stall done latency", n, 32'd7);
    chk("stall if_rdata", if_rdata, DBF);
    @(negedge clk);
    if_req = 1'b0;
    edge_sample();

    // ---- asynchronous reset mid-ACCESS of a store ----
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = A80; ls_wdata = 32'h1234_5678;
    edge_sample();
    chk("rststore grant mem_we", {31'b0, mem_we}, 32'h1);
    #1;
    rst = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    chk("rststore mem_en async", {31'b0, mem_en}, 32'h0);
    chk("rststore mem_we async", {31'b0, mem_we}, 32'h0);
    chk("rststore busy async", {31'b0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_sample();
      chk($sformatf("rststore%0d ls_done", k), {31'b0, ls_done}, 32'h0);
      chk($sformatf("rststore%0d busy", k), {31'b0, busy}, 32'h0);
    end
    chk("rststore no write", mem_arr[A80[7:2]], 32'h0);

    // ---- contention, both requests held: fetch, load, fetch ----
    exp_q.push_back({1'b0, 7'd3});
    exp_q.push_back({1'b1, 7'd7});
    exp_q.push_back({1'b0, 7'd11});
    @(negedge clk);
    if_req = 1'b1; if_addr = A10;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = A40;
    for (int k = 1; k <= 11; k++) begin
      edge_sample();
      if (k == 1) begin
        chk("cont first grant addr", mem_addr, A10);
        chk("cont first grant we", {31'b0, mem_we}, 32'h0);
      end
      if (if_done || ls_done) begin
        ev = {ls_done, 7'(k)};
        if (exp_q.size() == 0) chk("cont extra done", {24'b0, ev}, 32'h0);
        else chk("cont done order", {24'b0, ev}, {24'b0, exp_q.pop_front()});
        if (ls_done) chk("cont ls_rdata", ls_rdata, DBF);
        if (if_done) chk("cont if_rdata", if_rdata, W10);
      end
    end
    chk("cont missing done", exp_q.size(), 32'd0);
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    edge_sample();

    // ---- load request dropped after first ACCESS cycle ----
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = A10;
    edge_sample();
    chk("drop grant addr", mem_addr, A10);
    @(negedge clk);
    ls_req = 1'b0;
    edge_sample();
    chk("drop mem_en held", {31'b0, mem_en}, 32'h1);
    edge_sample();
    chk("drop ls_done", {31'b0, ls_done}, 32'h1);
    chk("drop ls_rdata", ls_rdata, W10);
    for (int k = 0; k < 5; k++) begin
      edge_sample();
      chk($sformatf("drop idle%0d mem_en", k), {31'b0, mem_en}, 32'h0);
      chk($sformatf("drop idle%0d done", k), {30'b0, if_done, ls_done}, 32'h0);
      chk($sformatf("drop idle%0d busy", k), {31'b0, busy}, 32'h0);
      chk($sformatf("drop idle%0d state", k), {30'b0, fsm_state}, 32'h0);
    end
    chk("drop ls_rdata holds", ls_rdata, W10);

    // ---- final report ----
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (multicycle controller, fetch state) and the load/store requester (memory-access states).
- Sequences each access through a fixed wait-state window.
- Arbitrates round-robin on contention and returns read data plus a one-cycle done pulse to the granted requester.
- Sits between controller/datapath and the memory model; all activity is qualified by the global clk_en.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, enabled cycles mem_en is held per access. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clk_en  input  1  global step enable; when low, all state freezes.
- if_req  input  1  fetch request; held until if_done.
- if_addr  input  ADDR_W  fetch address.
- if_rdata  output  DATA_W  fetched word; valid when if_done=1.
- if_done  output  1  one-cycle completion pulse for fetch.
- ls_req  input  1  load/store request; held until ls_done.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  data address.
- ls_wdata  input  DATA_W  store data.
- ls_rdata  output  DATA_W  load data; valid when ls_done=1.
- ls_done  output  1  one-cycle completion pulse for load/store.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid while mem_en=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low.
  - All outputs are registered.
  - Every state element advances only on a rising clk edge with clk_en=1. With clk_en=0, state, counter and all outputs hold.
- Reset (rst=0, any state): state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, busy=0, last_grant=LS (so fetch wins the first contention), wait counter=0.
  - Reset mid-access abandons the access; no done pulse is issued.
- State IDLE:
  - Samples if_req/ls_req.
  - Only one asserted: grant it.
  - Both asserted: grant the requester opposite to last_grant.
  - On grant: latch addr, we (fetch forces we=0) and wdata into the mem_* registers; set mem_en=1 and mem_we=latched we; load counter=WAIT_CYCLES-1; record grant and update last_grant; go to ACCESS.
  - No request: stay in IDLE.
- State ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata stay stable.
  - Counter>0: decrement and stay.
  - Counter==0: capture mem_rdata into the granted requester's rdata register (loads and fetches only; ls_rdata holds on a store); clear mem_en and mem_we; pulse the granted requester's done; go to DONE.
- State DONE:
  - The done output is high for exactly this one enabled cycle, then clears.
  - Go to IDLE; no back-to-back grant from DONE.
- Latency: a request sampled in IDLE at enabled edge N gives mem_en high for edges N+1..N+WAIT_CYCLES and done high after edge N+WAIT_CYCLES+1 (e.g. 3 enabled cycles for WAIT_CYCLES=2). The rdata register holds its value until overwritten by that requester's next access.
- Requester rules:
  - Requester drops req on the edge it samples done=1. A req still high in IDLE is treated as a new request.
  - If req drops during ACCESS, the access completes anyway and done still pulses; the memory write is not cancellable.
  - Address, wdata and we changes after grant are ignored.
- The non-granted requester waits with no done; its req is re-evaluated on the next IDLE cycle.
- WAIT_CYCLES=1: ACCESS lasts exactly one enabled cycle.
- Counter width is 4 bits.

Test Plan:
- Single fetch, WAIT_CYCLES=2, memory word at 0x0000_0010 = 0x2008_0005: if_req with if_addr=0x10 -> mem_en=1, mem_we=0, mem_addr=0x10 for 2 enabled cycles; if_done pulses 1 cycle later with if_rdata=0x2008_0005; ls_done stays 0.
- Store then fetch: ls_req, ls_we=1, ls_addr=0x40, ls_wdata=0xDEAD_BEEF -> mem_we=1 with those values for 2 cycles, ls_done pulses, ls_rdata unchanged. Then fetch 0x40 -> if_rdata=0xDEAD_BEEF.
- Contention after reset, both req held continuously: fetch granted first, then load/store, then fetch. Each done arrives 4 enabled cycles apart (3 access + 1 IDLE).
- clk_en stall: clk_en low for 5 cycles mid-ACCESS -> mem_en and mem_addr hold, counter frozen; done arrives exactly 5 clocks later than the unstalled case.
- Reset mid-ACCESS of a store: rst low for 1 cycle -> mem_en=0, mem_we=0, busy=0 immediately (asynchronous); no ls_done; next contention grants fetch first.
- Request drop: ls_req (load) deasserted after its first ACCESS cycle -> access still completes; ls_done pulses with ls_rdata=mem word; arbiter returns to IDLE and grants nothing further.
